nios_debug_arbiter: RTL and testbench
=====================================

Name: nios_debug_arbiter

Overview:
Shares the single 32-bit debug PIO input between up to four hardware debug requesters (audio, key-detect, FFT and similar blocks). It arbitrates round-robin and latches one tagged word onto the PIO in_port. It holds that word until the Nios software reads PIO address 0, or until a timeout drops the word. The block sits between the requesting datapath blocks and the debug PIO slave in the nios Qsys subsystem.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..4.
DATA_W, 28, payload width per requester; legal range 1..28. Zero-extended to 28 bits in the word.
TIMEOUT, 1024, cycles a word is held without a CPU read before it is dropped; must be >= 2.
CNT_W, 11, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
req  in  NUM_REQ  level request per requester; bit i = requester i.
req_data  in  NUM_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
ack  out  NUM_REQ  one-cycle grant/capture pulse per requester.
pio_rd  in  1  CPU read strobe of PIO address 0 (chipselect & read & address==0), one cycle.
in_port  out  32  word to the PIO: [31]=valid, [30]=overflow, [29:28]=tag, [27:0]=payload.
busy  out  1  high while in HOLD.

Behaviour:
- States: IDLE, HOLD. Reset: state=IDLE, in_port=0, ack=0, busy=0, rr pointer=0, overflow=0, timeout counter=0. Reset has priority over every other event, including reset mid-HOLD: the held word is discarded and no ack is reissued.
- IDLE, some req bit high at edge t:
  - Pick the first set bit searching from rr pointer upward, with wrap (rr pointer = index after last grant; 0 after reset).
  - At edge t: latch {1, overflow, tag=i, zero-extended req_data[i]} into in_port; set ack[i]=1 for exactly cycle t+1; rr pointer<=(i+1) mod NUM_REQ; enter HOLD.
  - Latency: req sampled at edge t gives in_port valid and ack during cycle t+1.
- IDLE, no req: in_port[31]=0; payload bits keep their last value; overflow bit stays visible in [30].
- HOLD: counter increments every cycle. Requests are ignored and no ack is issued.
- HOLD, pio_rd=1 at edge: in_port[31]<=0; overflow<=0 (including in_port[30]); counter<=0; enter IDLE. The CPU registered the word (including the valid bit) on the same edge.
- HOLD, counter==TIMEOUT-1 with pio_rd=0: word dropped; in_port[31]<=0; overflow<=1; counter<=0; enter IDLE.
- Read and timeout on the same edge: the read wins and overflow is cleared.
- pio_rd while IDLE: no effect. It does not clear overflow.
- After any exit from HOLD there is at least one IDLE cycle with valid=0 before the next word. Minimum spacing between words is 2 cycles after the read.
- Requester contract:
  - Hold req and req_data stable until ack.
  - After ack, drop req or present the next word in the following cycle.
  - If req is dropped before grant, nothing is captured.
- Width rule: payload bits above DATA_W are forced to 0. Unused tag codes never appear.
- All outputs are registered. There is no combinational path from req or pio_rd to any output.

Test Plan:
- Reset, then req=4'b0001, data0=28'h0ABCDEF → cycle after: ack=0001 for 1 cycle, in_port=32'h80ABCDEF (valid=1, tag=0), busy=1. pio_rd pulse → next cycle in_port[31]=0, busy=0.
- req=4'b1111 held, read each word immediately → tags granted in order 0,1,2,3,0; each ack is a single-cycle pulse; at least one valid=0 cycle between words.
- TIMEOUT=8, grant requester 2, no read → valid drops exactly 8 cycles after capture and overflow=1. Next grant of requester 1 data 28'h1 → in_port=32'hD0000001. A read then clears overflow.
- Counter at TIMEOUT-1 coincident with pio_rd → word counts as read, overflow stays 0.
- Assert reset during HOLD while req=4'b0100 → in_port=0, ack=0, rr pointer=0. After release, requester 2 is granted with a fresh ack.
- DATA_W=16, NUM_REQ=2, data1=16'hFFFF → in_port=32'h9000FFFF, bits [27:16]=0.

Source files
------------

// File: rtl/nios_debug_arbiter_if.sv
// Bundles the requester handshake and debug PIO signals of the debug arbiter.
// The master side is the requesting datapath blocks plus the CPU read strobe;
// the slave side is the arbiter, which owns ack, in_port and busy.
interface nios_debug_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 28
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      pio_rd;
  logic [31:0]               in_port;
  logic                      busy;

  modport master (
    output req,
    output req_data,
    output pio_rd,
    input  ack,
    input  in_port,
    input  busy
  );

  modport slave (
    input  req,
    input  req_data,
    input  pio_rd,
    output ack,
    output in_port,
    output busy
  );
endinterface

// File: rtl/nios_debug_arbiter.sv
// Round-robin arbiter that shares one 32-bit debug PIO word between up to four
// hardware requesters. A granted word is held on in_port until the CPU reads
// PIO address 0 or the hold timer expires, in which case the word is dropped
// and the sticky overflow flag is raised in bit 30.
// Word layout: [31]=valid, [30]=overflow, [29:28]=tag, [27:0]=payload.
module nios_debug_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 28,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic                clk,
  input  logic                reset,
  nios_debug_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [2:0]       NREQ3    = 3'(NUM_REQ);
  localparam logic [1:0]       LAST_IDX = 2'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               r_state;
  logic [31:0]          r_inPort;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 r_busy;
  logic [1:0]           r_rrPtr;
  logic                 r_overflow;
  logic [CNT_W-1:0]     r_count;

  logic [3:0]           w_reqPad;
  logic                 w_grantValid;
  logic [1:0]           w_grantIdx;
  logic [1:0]           w_nextPtr;
  logic [3:0]           w_ackOneHot;
  logic [27:0]          w_payload;

  assign w_reqPad    = 4'(bus.req);
  assign w_nextPtr   = (w_grantIdx == LAST_IDX) ? 2'd0 : w_grantIdx + 2'd1;
  assign w_ackOneHot = 4'b0001 << w_grantIdx;

  // Find the first requesting index at or after the round-robin pointer, wrapping.
  always_comb begin
    logic [2:0] cand;
    w_grantValid = 1'b0;
    w_grantIdx   = 2'd0;
    cand         = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, r_rrPtr} + 3'(k);
      if (cand >= NREQ3) begin
        cand = cand - NREQ3;
      end
      if (!w_grantValid && w_reqPad[cand[1:0]]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = cand[1:0];
      end
    end
  end

  // Select the granted requester's payload and zero-extend it to 28 bits.
  always_comb begin
    w_payload = 28'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grantIdx == 2'(i)) begin
        w_payload = 28'(bus.req_data[i*DATA_W +: DATA_W]);
      end
    end
  end

  // Capture/hold state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_inPort   <= 32'd0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
      r_rrPtr    <= 2'd0;
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_grantValid) begin
            r_inPort <= {1'b1, r_overflow, w_grantIdx, w_payload};
            r_ack    <= NUM_REQ'(w_ackOneHot);
            r_rrPtr  <= w_nextPtr;
            r_busy   <= 1'b1;
            r_count  <= '0;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (bus.pio_rd) begin
            r_inPort[31] <= 1'b0;
            r_inPort[30] <= 1'b0;
            r_overflow   <= 1'b0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else if (r_count == CNT_LAST) begin
            r_inPort[31] <= 1'b0;
            r_inPort[30] <= 1'b1;
            r_overflow   <= 1'b1;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_port = r_inPort;
  assign bus.ack     = r_ack;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_nios_debug_arbiter.sv
// Directed bench for nios_debug_arbiter. DUT A uses four 28-bit requesters and
// a short hold timer; DUT B uses two 16-bit requesters for the width rule.
// Expected words are queued when requests are driven and popped when a valid
// word appears on in_port.
module tb_nios_debug_arbiter;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  ack;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  nios_debug_arbiter_if #(.NUM_REQ(4), .DATA_W(28)) busA ();
  nios_debug_arbiter_if #(.NUM_REQ(2), .DATA_W(16)) busB ();

  nios_debug_arbiter #(.NUM_REQ(4), .DATA_W(28), .TIMEOUT(8), .CNT_W(4)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  nios_debug_arbiter #(.NUM_REQ(2), .DATA_W(16), .TIMEOUT(16), .CNT_W(5)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    assert (actual === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [111:0] data);
    busA.req      = mask;
    busA.req_data = data;
  endtask

  task automatic expectWord(input logic [31:0] word, input logic [3:0] ack);
    exp_t e;
    e.word = word;
    e.ack  = ack;
    sbQ.push_back(e);
  endtask

  task automatic awaitWord(input string tag, input int maxCycles);
    exp_t e;
    bit   found;
    found = 1'b0;
    for (int c = 0; c < maxCycles && !found; c++) begin
      tick();
      if (busA.in_port[31] === 1'b1) found = 1'b1;
    end
    checkOutput({tag, "_seen"}, 32'(found), 32'd1);
    checkOutput({tag, "_sbq"}, 32'(sbQ.size() != 0), 32'd1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_word"}, busA.in_port, e.word);
      checkOutput({tag, "_ack"}, 32'(busA.ack), 32'(e.ack));
      checkOutput({tag, "_busy"}, 32'(busA.busy), 32'd1);
    end
    tick();
    checkOutput({tag, "_ackpulse"}, 32'(busA.ack), 32'd0);
    checkOutput({tag, "_held"}, 32'(busA.in_port[31]), 32'd1);
  endtask

  task automatic cpuRead(input string tag);
    busA.pio_rd = 1'b1;
    tick();
    busA.pio_rd = 1'b0;
    checkOutput({tag, "_rdvalid"}, 32'(busA.in_port[31]), 32'd0);
    checkOutput({tag, "_rdbusy"}, 32'(busA.busy), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    busA.req      = '0;
    busA.req_data = '0;
    busA.pio_rd   = 1'b0;
    busB.req      = '0;
    busB.req_data = '0;
    busB.pio_rd   = 1'b0;
    tick();
    tick();
    checkOutput("rst_inport", busA.in_port, 32'd0);
    checkOutput("rst_ack", 32'(busA.ack), 32'd0);
    checkOutput("rst_busy", 32'(busA.busy), 32'd0);
    reset = 1'b0;

    $display("[TB] single grant and read");
    applyStimulus(4'b0001, {28'h0, 28'h0, 28'h0, 28'h0ABCDEF});
    expectWord(32'h80ABCDEF, 4'b0001);
    awaitWord("s1", 4);
    busA.req = '0;
    cpuRead("s1");
    checkOutput("s1_after", busA.in_port, 32'h00ABCDEF);

    $display("[TB] round robin with all requests held");
    doReset();
    applyStimulus(4'b1111, {28'h00A0003, 28'h00A0002, 28'h00A0001, 28'h00A0000});
    expectWord(32'h800A0000, 4'b0001);
    expectWord(32'h900A0001, 4'b0010);
    expectWord(32'hA00A0002, 4'b0100);
    expectWord(32'hB00A0003, 4'b1000);
    expectWord(32'h800A0000, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      awaitWord($sformatf("rr%0d", i), 4);
      if (i == 4) busA.req = '0;
      cpuRead($sformatf("rr%0d", i));
    end

    $display("[TB] timeout drops word and raises overflow");
    doReset();
    applyStimulus(4'b0100, {28'h0, 28'h0000222, 28'h0, 28'h0});
    expectWord(32'hA0000222, 4'b0100);
    awaitWord("to", 4);
    busA.req = '0;
    repeat (6) tick();
    checkOutput("to_lastcycle", busA.in_port, 32'hA0000222);
    tick();
    checkOutput("to_dropped", busA.in_port, 32'h60000222);
    checkOutput("to_busy", 32'(busA.busy), 32'd0);
    busA.pio_rd = 1'b1;
    tick();
    busA.pio_rd = 1'b0;
    checkOutput("idle_read", busA.in_port, 32'h60000222);
    applyStimulus(4'b0010, {28'h0, 28'h0, 28'h0000001, 28'h0});
    expectWord(32'hD0000001, 4'b0010);
    awaitWord("ovf", 4);
    busA.req = '0;
    cpuRead("ovf");
    checkOutput("ovf_cleared", busA.in_port, 32'h10000001);

    $display("[TB] read coincident with timeout");
    applyStimulus(4'b1000, {28'h0000333, 28'h0, 28'h0, 28'h0});
    expectWord(32'hB0000333, 4'b1000);
    awaitWord("co", 4);
    busA.req = '0;
    repeat (6) tick();
    busA.pio_rd = 1'b1;
    tick();
    busA.pio_rd = 1'b0;
    checkOutput("co_readwins", busA.in_port, 32'h30000333);
    applyStimulus(4'b0001, {28'h0, 28'h0, 28'h0, 28'h0000005});
    expectWord(32'h80000005, 4'b0001);
    awaitWord("co_next", 4);
    busA.req = '0;
    cpuRead("co_next");

    $display("[TB] reset during hold");
    applyStimulus(4'b0100, {28'h0, 28'h0000777, 28'h0, 28'h0});
    expectWord(32'hA0000777, 4'b0100);
    awaitWord("mr", 4);
    reset = 1'b1;
    tick();
    checkOutput("mr_inport", busA.in_port, 32'd0);
    checkOutput("mr_ack", 32'(busA.ack), 32'd0);
    checkOutput("mr_busy", 32'(busA.busy), 32'd0);
    checkOutput("mr_rrptr", 32'(dutA.r_rrPtr), 32'd0);
    tick();
    checkOutput("mr_ack2", 32'(busA.ack), 32'd0);
    checkOutput("mr_inport2", busA.in_port, 32'd0);
    reset = 1'b0;
    expectWord(32'hA0000777, 4'b0100);
    awaitWord("mr_fresh", 4);
    busA.req = '0;
    cpuRead("mr_fresh");

    $display("[TB] narrow payload with two requesters");
    busB.req      = 2'b10;
    busB.req_data = {16'hFFFF, 16'h1234};
    tick();
    checkOutput("nw_word", busB.in_port, 32'h9000FFFF);
    checkOutput("nw_ack", 32'(busB.ack), 32'd2);
    checkOutput("nw_busy", 32'(busB.busy), 32'd1);
    busB.req = '0;
    tick();
    checkOutput("nw_ackpulse", 32'(busB.ack), 32'd0);
    busB.pio_rd = 1'b1;
    tick();
    busB.pio_rd = 1'b0;
    checkOutput("nw_read", busB.in_port, 32'h1000FFFF);
    checkOutput("nw_rdbusy", 32'(busB.busy), 32'd0);

    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
